uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, one or two
// stop bits. Frame settings are captured at the handshake and held for the whole frame.
//
// state  | meaning
// IDLE   | line high, tx_ready=1, waiting for tx_valid
// START  | start bit (line low)
// DATA   | payload bits, LSB first
// PARITY | parity bit (skipped when parity is disabled)
// STOP   | one or two stop bit periods (line high)
module uart_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [2:0]        parity_type,
  input  logic              stop_bits,
  output logic              tx_out,
  output logic              busy,
  output logic              parity_bit,
  output logic              frame_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Counter must reach 2*CLKS_PER_BIT-1 so a double stop bit is timed in one span.
  localparam int CNT_W = $clog2(2 * CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP2_LAST = CNT_W'(2 * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q;
  logic              stop2_q;

  logic par_en_d;
  logic par_d;
  logic bit_end;
  logic stop_end;

  always_comb begin
    par_en_d = 1'b1;
    par_d    = 1'b0;
    case (parity_type)
      3'b001:  par_d = ~^tx_data;
      3'b010:  par_d = ^tx_data;
      3'b011:  par_d = 1'b1;
      3'b100:  par_d = 1'b0;
      default: par_en_d = 1'b0;
    endcase
  end

  assign bit_end  = (clk_cnt == BIT_LAST);
  assign stop_end = stop2_q ? (clk_cnt == STOP2_LAST) : bit_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      parity_bit <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (tx_valid) begin
            state      <= S_START;
            shift_q    <= tx_data;
            par_en_q   <= par_en_d;
            parity_bit <= par_d;
            stop2_q    <= stop_bits;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            shift_q <= shift_q >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (stop_end) begin
            clk_cnt    <= '0;
            state      <= S_IDLE;
            frame_done <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          clk_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Line level is decoded from registered state, so the start bit appears in the
  // first cycle after acceptance.
  always_comb begin
    tx_out = 1'b1;
    case (state)
      S_START:  tx_out = 1'b0;
      S_DATA:   tx_out = shift_q[0];
      S_PARITY: tx_out = parity_bit;
      default:  tx_out = 1'b1;
    endcase
  end

  assign tx_ready = (state == S_IDLE);
  assign busy     = ~tx_ready;

endmodule
